round_robin_arbiter4: RTL and testbench

ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

---
 rtl/round_robin_arbiter4.sv | 134 +++++++++++++
 tb/tb_round_robin_arbiter4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter4.sv
// round_robin_arbiter4
//   Four-requester round-robin arbiter with a bounded grant hold time.
//   A grant is issued one cycle after a request is sampled in IDLE. It is
//   held while the owner keeps requesting, for at most MAX_HOLD cycles.
//   When the limit is hit the grant is withdrawn and timeout pulses for one
//   cycle. At least one IDLE cycle separates consecutive grants.
//
// Parameters
//   MAX_HOLD  : maximum consecutive cycles a grant may be held (1..255)
//
// Ports
//   clk       : in  system clock, rising edge
//   rst       : in  synchronous active-high reset
//   req[3:0]  : in  level request vector, bit i = requester i
//   gnt[3:0]  : out registered one-hot grant
//   gnt_idx   : out registered binary index of the owner (0 when idle)
//   gnt_valid : out high exactly when gnt is non-zero
//   timeout   : out one-cycle pulse marking a forced grant release

module round_robin_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_idx;
  logic       r_timeout;

  state_t     w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [7:0] w_cnt_nxt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_gnt_idx_nxt;
  logic       w_timeout_nxt;

  logic       w_found;
  logic [1:0] w_pick;

  // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the last owner is checked last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!w_found && req[2'(r_ptr + 2'(k))]) begin
        w_found = 1'b1;
        w_pick  = 2'(r_ptr + 2'(k));
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_idx_nxt = r_gnt_idx;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_gnt_nxt     = '0;
        w_gnt_idx_nxt = '0;
        if (w_found) begin
          w_state_nxt   = BUSY;
          w_gnt_nxt     = 4'b0001 << w_pick;
          w_gnt_idx_nxt = w_pick;
          w_ptr_nxt     = w_pick;
          w_cnt_nxt     = 8'd1;
        end
      end
      BUSY: begin
        if (!req[r_gnt_idx]) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_gnt_idx_nxt = '0;
        end else if (r_cnt >= MAX_CNT) begin
          // Forced release; ptr already names this owner, so it ranks last.
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_gnt_idx_nxt = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_gnt_nxt     = '0;
        w_gnt_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd3;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = |r_gnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
module tb_round_robin_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  round_robin_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       tout;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       tout;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_gnt"},       {4'd0, gnt},       {4'd0, e.gnt});
    chk({e.name, "_idx"},       {6'd0, gnt_idx},   {6'd0, e.idx});
    chk({e.name, "_valid"},     {7'd0, gnt_valid}, {7'd0, e.valid});
    chk({e.name, "_timeout"},   {7'd0, timeout},   {7'd0, e.tout});
    chk({e.name, "_onehot"},    {7'd0, ($countones(gnt) <= 1)}, 8'd1);
    chk({e.name, "_valid_or"},  {7'd0, gnt_valid}, {7'd0, |gnt});
    chk({e.name, "_idx_enc"},   {6'd0, gnt_idx},   {6'd0, enc(gnt)});
  endtask

  // Drive one cycle of inputs, queue the expected outputs for after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input logic tout, input string name);
    exp_t e;
    e.gnt   = g;
    e.idx   = enc(g);
    e.valid = |g;
    e.tout  = tout;
    e.name  = name;
    rst = r;
    req = rq;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                              input logic tout, input string name);
    vec_t v;
    v.rst  = r;
    v.req  = rq;
    v.gnt  = g;
    v.tout = tout;
    v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset / first grant, then the all-values sweep from ptr=3.
    add(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
    add(1'b0, 4'b0000, 4'b0000, 1'b0, "idle_noreq");
    add(1'b1, 4'b0110, 4'b0000, 1'b0, "reset_req");
    add(1'b0, 4'b0110, 4'b0010, 1'b0, "first_grant");
    for (int v = 0; v < 16; v++) begin
      add(1'b1, 4'(v), 4'b0000, 1'b0, $sformatf("sweep_rst%0d", v));
      add(1'b0, 4'(v), lowest(4'(v)), 1'b0, $sformatf("sweep%0d", v));
    end
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].tout, vecs[i].name);

    // Rotation with all requesting; each owner drops after two granted cycles.
    step(1'b1, 4'b1111, 4'b0000, 1'b0, "rot_rst");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_g0a");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_g0b");
    step(1'b0, 4'b1110, 4'b0000, 1'b0, "rot_idle0");
    step(1'b0, 4'b1111, 4'b0010, 1'b0, "rot_g1a");
    step(1'b0, 4'b1111, 4'b0010, 1'b0, "rot_g1b");
    step(1'b0, 4'b1101, 4'b0000, 1'b0, "rot_idle1");
    step(1'b0, 4'b1111, 4'b0100, 1'b0, "rot_g2a");
    step(1'b0, 4'b1111, 4'b0100, 1'b0, "rot_g2b");
    step(1'b0, 4'b1011, 4'b0000, 1'b0, "rot_idle2");
    step(1'b0, 4'b1111, 4'b1000, 1'b0, "rot_g3a");
    step(1'b0, 4'b1111, 4'b1000, 1'b0, "rot_g3b");
    step(1'b0, 4'b0111, 4'b0000, 1'b0, "rot_idle3");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "rot_g0again");

    // Single requester hits the hold limit, then is granted again.
    step(1'b1, 4'b0001, 4'b0000, 1'b0, "hold_rst");
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0001, 4'b0001, 1'b0, $sformatf("hold_c%0d", i + 1));
    step(1'b0, 4'b0001, 4'b0000, 1'b1, "hold_timeout");
    step(1'b0, 4'b0001, 4'b0001, 1'b0, "hold_regrant");

    // Timed-out owner ranks last: next grant goes to 2.
    step(1'b1, 4'b0101, 4'b0000, 1'b0, "to_rst");
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0101, 4'b0001, 1'b0, $sformatf("to_c%0d", i + 1));
    step(1'b0, 4'b0101, 4'b0000, 1'b1, "to_timeout");
    step(1'b0, 4'b0101, 4'b0100, 1'b0, "to_next2");

    // Other requests during BUSY are ignored; reset mid-grant drops it.
    step(1'b1, 4'b0100, 4'b0000, 1'b0, "br_rst");
    step(1'b0, 4'b0100, 4'b0100, 1'b0, "br_g2");
    step(1'b0, 4'b1111, 4'b0100, 1'b0, "br_others_on");
    step(1'b0, 4'b0101, 4'b0100, 1'b0, "br_others_mix");
    step(1'b1, 4'b1111, 4'b0000, 1'b0, "br_reset_busy");
    step(1'b0, 4'b1111, 4'b0001, 1'b0, "br_after_rst");

    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
